// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1R1W output buffer.
// Byte-merge is common to the array write path and the read bypass.
package sram_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 14;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic logic [7:0] merge_be(
    input logic [7:0] old_b,
    input logic [7:0] new_b,
    input logic       be
  );
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/sram_1r1w_array.sv
// Pure storage: byte-masked synchronous write, combinational read.
// No reset so it can map onto a memory macro.
module sram_1r1w_array
  import sram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        mem[waddr][8*b +: 8] <= merge_be(
          mem[waddr][8*b +: 8],
          wdata[8*b +: 8],
          be[b]);
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sram_1r1w_p.sv
// Parametrised 1R1W buffer: clear sequencer, byte-masked writes,
// registered read port with same-address write forwarding.
module sram_1r1w_p
  import sram_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  ready,
  input  logic                  WE,
  input  logic [DATA_W/8-1:0]   WByteEn,
  input  logic [ADDR_W-1:0]     WriteAddress,
  input  logic [DATA_W-1:0]     WriteBus,
  input  logic                  RE,
  input  logic [ADDR_W-1:0]     ReadAddress,
  output logic [DATA_W-1:0]     ReadBus,
  output logic                  ReadValid
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              hold;
  logic              hold_nxt;
  logic              sweep;

  logic              act;
  logic              wr;
  logic              rd;
  logic              a_we;
  logic [BE_W-1:0]   a_be;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] a_rdata;
  logic [DATA_W-1:0] rd_word;

  // A requested clear idles one cycle before sweeping (hold).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
      hold  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hold  <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = 1'b0;
    sweep     = 1'b0;
    unique case (state)
      CLEAR: begin
        if (!hold) begin
          sweep   = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST) state_nxt = READY;
        end
      end
      READY: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
          hold_nxt  = 1'b1;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign ready = (state == READY);
  assign act   = ready && !clear_req;
  assign wr    = act && WE;
  assign rd    = act && RE;

  assign a_we   = sweep || wr;
  assign a_be   = sweep ? '1 : WByteEn;
  assign a_addr = sweep ? cnt : WriteAddress;
  assign a_data = sweep ? CLEAR_VAL : WriteBus;

  sram_1r1w_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock (clock),
    .we    (a_we),
    .be    (a_be),
    .waddr (a_addr),
    .wdata (a_data),
    .raddr (ReadAddress),
    .rdata (a_rdata)
  );

  always_comb begin
    rd_word = a_rdata;
    if (wr && (ReadAddress == WriteAddress)) begin
      for (int b = 0; b < BE_W; b++) begin
        rd_word[8*b +: 8] = merge_be(
          a_rdata[8*b +: 8],
          WriteBus[8*b +: 8],
          WByteEn[b]);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ReadBus   <= '0;
      ReadValid <= 1'b0;
    end else begin
      ReadValid <= rd;
      if (rd) ReadBus <= rd_word;
    end
  end

endmodule

// File: tb/tb_sram_1r1w_p.sv
// Directed bench for sram_1r1w_p at DEPTH=16, CLEAR_VAL=16'hA5A5.
// Inputs change 1ns after each rising edge; outputs sampled there too.
module tb_sram_1r1w_p;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam logic [DW-1:0] CV = 16'hA5A5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear_req = 1'b0;
  logic          ready;
  logic          WE = 1'b0;
  logic [1:0]    WByteEn = '0;
  logic [AW-1:0] WriteAddress = '0;
  logic [DW-1:0] WriteBus = '0;
  logic          RE = 1'b0;
  logic [AW-1:0] ReadAddress = '0;
  logic [DW-1:0] ReadBus;
  logic          ReadValid;

  int n_chk = 0;
  int n_pass = 0;
  int n;
  int rv_seen;

  always #5 clock = ~clock;

  sram_1r1w_p #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .CLEAR_VAL (CV)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear_req    (clear_req),
    .ready        (ready),
    .WE           (WE),
    .WByteEn      (WByteEn),
    .WriteAddress (WriteAddress),
    .WriteBus     (WriteBus),
    .RE           (RE),
    .ReadAddress  (ReadAddress),
    .ReadBus      (ReadBus),
    .ReadValid    (ReadValid)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd_chk(
    input string         tag,
    input logic [AW-1:0] a,
    input logic [DW-1:0] exp
  );
    RE = 1'b1;
    ReadAddress = a;
    step();
    RE = 1'b0;
    chk({tag, "_rv"}, 32'(ReadValid), 32'd1);
    chk(tag, 32'(ReadBus), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rv", 32'(ReadValid), 32'd0);
    chk("rst_rbus", 32'(ReadBus), 32'd0);

    // Release reset with WE/RE held high through the sweep
    reset_n = 1'b1;
    WE = 1'b1;
    RE = 1'b1;
    WByteEn = 2'b11;
    WriteAddress = 4'd2;
    WriteBus = 16'h1111;
    ReadAddress = 4'd2;
    n = 0;
    rv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (ReadValid) rv_seen++;
      if (ready) break;
    end
    WE = 1'b0;
    RE = 1'b0;
    chk("sweep_len", 32'(n), 32'd16);
    chk("sweep_rv", 32'(rv_seen), 32'd0);

    for (int a = 0; a < 16; a++) begin
      rd_chk("clr_rd", 4'(a), CV);
    end
    step();
    chk("idle_rv", 32'(ReadValid), 32'd0);
    chk("idle_hold", 32'(ReadBus), 32'hA5A5);

    // Low-byte-only write
    WE = 1'b1;
    WriteAddress = 4'd5;
    WriteBus = 16'h1234;
    WByteEn = 2'b01;
    step();
    WE = 1'b0;
    rd_chk("be01", 4'd5, 16'hA534);

    // Same-address forwarding with high byte only
    WE = 1'b1;
    WriteAddress = 4'd7;
    WriteBus = 16'h0000;
    WByteEn = 2'b11;
    step();
    WriteBus = 16'hBEEF;
    WByteEn = 2'b10;
    RE = 1'b1;
    ReadAddress = 4'd7;
    step();
    WE = 1'b0;
    RE = 1'b0;
    chk("fwd_rv", 32'(ReadValid), 32'd1);
    chk("fwd", 32'(ReadBus), 32'hBE00);
    rd_chk("fwd_later", 4'd7, 16'hBE00);

    // Independent read and write in one cycle
    WE = 1'b1;
    WriteAddress = 4'd9;
    WriteBus = 16'h9999;
    WByteEn = 2'b11;
    RE = 1'b1;
    ReadAddress = 4'd5;
    step();
    WE = 1'b0;
    RE = 1'b0;
    chk("indep_rd", 32'(ReadBus), 32'hA534);
    rd_chk("indep_wr", 4'd9, 16'h9999);

    // Zero byte-enable leaves the word alone
    WE = 1'b1;
    WriteAddress = 4'd9;
    WriteBus = 16'h0000;
    WByteEn = 2'b00;
    step();
    WE = 1'b0;
    rd_chk("be00", 4'd9, 16'h9999);

    // clear_req drops the concurrent write and read
    clear_req = 1'b1;
    WE = 1'b1;
    WriteAddress = 4'd3;
    WriteBus = 16'h5555;
    WByteEn = 2'b11;
    RE = 1'b1;
    ReadAddress = 4'd9;
    step();
    clear_req = 1'b0;
    WE = 1'b0;
    RE = 1'b0;
    chk("creq_ready", 32'(ready), 32'd0);
    chk("creq_rv", 32'(ReadValid), 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready) break;
      n++;
      step();
    end
    chk("creq_len", 32'(n), 32'd17);
    rd_chk("creq_a3", 4'd3, CV);
    rd_chk("creq_a9", 4'd9, CV);

    // Reset mid-sweep with the counter at 8
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (9) step();
    chk("mid_ready", 32'(ready), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_rv", 32'(ReadValid), 32'd0);
    chk("arst_rbus", 32'(ReadBus), 32'd0);
    step();
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (ready) break;
    end
    chk("resweep_len", 32'(n), 32'd16);
    rd_chk("resweep_a0", 4'd0, CV);
    rd_chk("resweep_a15", 4'd15, CV);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
